// File: rtl/stdout_uart_tx.sv
// Console transmitter: byte stores to the stdout window are queued in a FIFO
// and drained onto an 8N1 serial line. A status word is readable at base+8.
package stdout_uart_pkg;
    typedef enum logic [1:0] {
        NO_STORE    = 2'd0,
        STORE_BYTE  = 2'd1,
        STORE_WORD  = 2'd2,
        STORE_DWORD = 2'd3
    } mem_store_type_t;

    localparam logic [63:0] STDOUT_BASE_ADDR = 64'h0000_0000_1000_0000;
endpackage

module stdout_uart_tx
    import stdout_uart_pkg::*;
#(
    parameter int DEPTH        = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic [63:0]     addr,
    input  mem_store_type_t mem_store_type,
    input  logic [63:0]     w_data,
    output logic [63:0]     r_data,
    output logic            tx,
    output logic            tx_busy,
    output logic            fifo_full,
    output logic            overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state;
    logic [BW-1:0] baud;
    logic [2:0]    bit_idx;
    logic [7:0]    shift_reg;
    logic [7:0]    fifo_mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          overflow_r;
    logic          tx_r;

    logic       in_data_win;
    logic       in_status_win;
    logic       push_req;
    logic       push_ok;
    logic       clr_ovf;
    logic       pop;
    logic       baud_end;
    logic       shift_adv;
    logic       empty;
    logic [7:0] cnt8;
    logic       unused_w_data;

    assign in_data_win   = (addr >= STDOUT_BASE_ADDR) &&
                           (addr <  STDOUT_BASE_ADDR + 64'd8);
    assign in_status_win = (addr >= STDOUT_BASE_ADDR + 64'd8) &&
                           (addr <  STDOUT_BASE_ADDR + 64'd16);

    // Space is judged on the pre-edge count; a same-cycle pop does not help.
    assign push_req  = in_data_win && (mem_store_type == STORE_BYTE);
    assign push_ok   = push_req && (count < DEPTH_C);
    assign clr_ovf   = in_status_win && (mem_store_type != NO_STORE);
    assign pop       = (state == IDLE) && (count != '0);
    assign baud_end  = (baud == BAUD_LAST);
    assign shift_adv = (state == DATA) && baud_end && (bit_idx != 3'd7);

    assign unused_w_data = ^w_data[63:8];

    // Payload storage carries no reset; only the control state below does.
    always_ff @(posedge clock) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= w_data[7:0];
        end
        if (pop) begin
            shift_reg <= fifo_mem[rd_ptr];
        end else if (shift_adv) begin
            shift_reg <= {1'b0, shift_reg[7:1]};
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_r <= 1'b0;
            state      <= IDLE;
            baud       <= '0;
            bit_idx    <= '0;
            tx_r       <= 1'b1;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            if (push_req && !push_ok) begin
                overflow_r <= 1'b1;
            end else if (clr_ovf) begin
                overflow_r <= 1'b0;
            end

            // tx is registered alongside the state so it changes on the transition edge.
            case (state)
                IDLE: begin
                    tx_r <= 1'b1;
                    if (pop) begin
                        state <= START;
                        baud  <= '0;
                        tx_r  <= 1'b0;
                    end
                end
                START: begin
                    if (baud_end) begin
                        state   <= DATA;
                        baud    <= '0;
                        bit_idx <= '0;
                        tx_r    <= shift_reg[0];
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_end) begin
                        baud <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                            tx_r  <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            tx_r    <= shift_reg[1];
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                STOP: begin
                    tx_r <= 1'b1;
                    if (baud_end) begin
                        state <= IDLE;
                        baud  <= '0;
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    tx_r  <= 1'b1;
                end
            endcase
        end
    end

    assign empty     = (count == '0);
    assign cnt8      = 8'(count);
    assign tx        = tx_r;
    assign tx_busy   = (state != IDLE);
    assign fifo_full = (count == DEPTH_C);
    assign overflow  = overflow_r;
    assign r_data    = {52'd0, overflow_r, tx_busy, fifo_full, empty, cnt8};

endmodule

// File: tb/tb_stdout_uart_tx.sv
// Directed bench for stdout_uart_tx with DEPTH=4, CLKS_PER_BIT=4.
module tb_stdout_uart_tx;
    import stdout_uart_pkg::*;

    localparam int DEPTH = 4;
    localparam int CPB   = 4;
    localparam logic [63:0] BASE = STDOUT_BASE_ADDR;

    logic            clock = 1'b0;
    logic            reset_n;
    logic [63:0]     addr;
    mem_store_type_t mem_store_type;
    logic [63:0]     w_data;
    logic [63:0]     r_data;
    logic            tx;
    logic            tx_busy;
    logic            fifo_full;
    logic            overflow;

    int vectors     = 0;
    int miscompares = 0;

    stdout_uart_tx #(.DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .addr           (addr),
        .mem_store_type (mem_store_type),
        .w_data         (w_data),
        .r_data         (r_data),
        .tx             (tx),
        .tx_busy        (tx_busy),
        .fifo_full      (fifo_full),
        .overflow       (overflow)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Holds a store for exactly one sampling edge; upper data bits are junk on purpose.
    task automatic store(input logic [63:0] a, input mem_store_type_t t, input logic [7:0] d);
        addr           = a;
        mem_store_type = t;
        w_data         = {56'hFFEEDDCCBBAA99, d};
        tick();
        mem_store_type = NO_STORE;
        addr           = 64'd0;
    endtask

    // Called 'first' cycles after START entry; walks to the IDLE-entry edge.
    task automatic frame(input logic [7:0] b, input int first, input string tag);
        logic [9:0] bits;
        logic [3:0] s;
        bits = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            s = {4{bits[i]}};
            for (int j = 0; j < CPB; j++) begin
                if (i * CPB + j >= first) begin
                    s[j] = tx;
                    tick();
                end
            end
            if (i * CPB + CPB - 1 >= first)
                check($sformatf("%s_bit%0d", tag, i), 64'(s), 64'({4{bits[i]}}));
        end
    endtask

    initial begin
        logic seen_low;

        reset_n        = 1'b0;
        addr           = 64'd0;
        w_data         = 64'd0;
        mem_store_type = NO_STORE;
        tick(3);
        check("reset_rdata", r_data, 64'h100);
        check("reset_tx", 64'(tx), 64'd1);
        check("reset_busy", 64'(tx_busy), 64'd0);
        check("reset_full", 64'(fifo_full), 64'd0);
        check("reset_ovf", 64'(overflow), 64'd0);
        reset_n = 1'b1;
        tick(2);

        store(BASE + 64'd3, STORE_BYTE, 8'hA5);
        check("single_count", r_data, 64'h001);
        check("single_tx_before", 64'(tx), 64'd1);
        tick();
        check("single_busy", 64'(tx_busy), 64'd1);
        frame(8'hA5, 0, "single");
        check("single_busy_fall", 64'(tx_busy), 64'd0);
        check("single_idle_rdata", r_data, 64'h100);

        store(BASE, STORE_WORD, 8'h41);
        check("ign_word", r_data, 64'h100);
        store(BASE + 64'd4, STORE_DWORD, 8'h41);
        check("ign_dword", r_data, 64'h100);
        store(BASE + 64'd16, STORE_BYTE, 8'h41);
        check("ign_byte_above", r_data, 64'h100);
        store(BASE - 64'd1, STORE_BYTE, 8'h41);
        check("ign_byte_below", r_data, 64'h100);
        store(BASE + 64'd8, STORE_BYTE, 8'h41);
        check("ign_byte_status", r_data, 64'h100);
        tick();
        check("ign_tx", 64'(tx), 64'd1);
        check("ign_busy", 64'(tx_busy), 64'd0);

        for (int i = 0; i < 6; i++)
            store(BASE + 64'(i), STORE_BYTE, 8'(8'h30 + i));
        check("fill_rdata", r_data, 64'hE04);
        check("fill_full", 64'(fifo_full), 64'd1);
        check("fill_ovf", 64'(overflow), 64'd1);
        check("fill_tx", 64'(tx), 64'd0);

        store(BASE + 64'd8, STORE_DWORD, 8'h00);
        check("clr_ovf", 64'(overflow), 64'd0);
        check("clr_rdata", r_data, 64'h604);
        check("clr_tx", 64'(tx), 64'd0);
        frame(8'h30, 5, "f30");
        for (int i = 1; i < 5; i++) begin
            check($sformatf("gap%0d_busy", i), 64'(tx_busy), 64'd0);
            check($sformatf("gap%0d_count", i), 64'(r_data[7:0]), 64'(5 - i));
            tick();
            frame(8'(8'h30 + i), 0, $sformatf("f3%0d", i));
        end
        check("drain_rdata", r_data, 64'h100);

        store(BASE, STORE_BYTE, 8'hA5);
        tick();
        store(BASE + 64'd1, STORE_BYTE, 8'h11);
        store(BASE + 64'd2, STORE_BYTE, 8'h22);
        check("pre_reset_count", 64'(r_data[7:0]), 64'd2);
        tick(15);
        check("pre_reset_tx", 64'(tx), 64'd0);
        #3;
        reset_n = 1'b0;
        #2;
        check("async_reset_tx", 64'(tx), 64'd1);
        check("async_reset_rdata", r_data, 64'h100);
        tick();
        check("held_reset_rdata", r_data, 64'h100);
        reset_n  = 1'b1;
        seen_low = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (tx !== 1'b1) seen_low = 1'b1;
            tick();
        end
        check("post_reset_line_idle", 64'(seen_low), 64'd0);
        check("post_reset_rdata", r_data, 64'h100);

        for (int i = 0; i < 20; i++) begin
            store(BASE + 64'd7, STORE_BYTE, 8'(i));
            check($sformatf("wrap%0d_count", i), r_data, 64'h001);
            tick();
            frame(8'(i), 0, $sformatf("wrap%0d", i));
            check($sformatf("wrap%0d_idle", i), r_data, 64'h100);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
